wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, the result data width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port wb_stall, input, 1: when high, blocks all writeback acceptance.
REQ-005 SHALL have port alu_valid, input, 1: ALU result offered.
REQ-006 SHALL have port alu_ready, output, 1: ALU result accepted this cycle.
REQ-007 SHALL have port alu_rd, input, 5: ALU destination register index.
REQ-008 SHALL have port alu_data, input, XLEN: ALU result value.
REQ-009 SHALL have port lsu_valid, input, 1: load result offered.
REQ-010 SHALL have port lsu_ready, output, 1: load result accepted this cycle.
REQ-011 SHALL have port lsu_rd, input, 5: load destination register index.
REQ-012 SHALL have port lsu_data, input, XLEN: load result value.
REQ-013 SHALL have port wbe_CONTROL, output, 1: register-file write enable.
REQ-014 SHALL have port rd_sel, output, 5: register-file write index.
REQ-015 SHALL have port rd_in, output, XLEN: register-file write data.
REQ-016 SHALL have port retire_cnt, output, 32: count of accepted results.

Function
REQ-017 SHALL define a transfer on a source as valid && ready high on the same rising edge.
REQ-018 SHALL generate alu_ready and lsu_ready combinationally from valids, wb_stall, rst and the round-robin pointer.
REQ-019 SHALL assert at most one ready per cycle.
REQ-020 SHALL drive both readies low while wb_stall or rst is high.
REQ-021 SHALL grant the sole valid source when exactly one valid is high; no ready when neither is high.
REQ-022 SHALL grant the source named by a 1-bit round-robin pointer when both valids are high.
REQ-023 SHALL flip the pointer to the other source only after a contended grant; an uncontended grant leaves it unchanged.
REQ-024 SHALL register the granted rd and data into rd_sel and rd_in on the transfer edge: one-cycle latency.
REQ-025 SHALL hold rd_sel and rd_in at their last values in cycles without a transfer.
REQ-026 SHALL assert wbe_CONTROL for exactly the one cycle after each transfer with rd != 0; otherwise it SHALL be low.
REQ-027 SHALL accept a transfer with rd == 0 normally (ready, counted, rd_sel/rd_in updated), but wbe_CONTROL SHALL stay low.
REQ-028 SHALL increment retire_cnt by 1 per transfer, including rd == 0, wrapping 0xFFFFFFFF -> 0.
REQ-029 SHALL support back-to-back transfers every cycle with no bubble.
REQ-030 SHALL not require sources to hold valid; unaccepted offers are the source's responsibility and are not tracked.
REQ-031 SHALL take no action when wb_stall rises between cycles, beyond lowering readies; the output register update from the prior transfer still occurs.

Reset
REQ-032 SHALL on rst high immediately clear wbe_CONTROL, rd_sel, rd_in, retire_cnt and the pointer, independent of clk.
REQ-033 SHALL set the pointer reset value to the ALU.
REQ-034 SHALL discard any offer present while rst is high.
REQ-035 SHALL resume arbitration on the first rising edge after rst deasserts, with no extra wait.

Verification
REQ-036 Single ALU: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> alu_ready=1 that cycle; next cycle wbe_CONTROL=1, rd_sel=5, rd_in=0xDEADBEEF, retire_cnt=1; following cycle wbe_CONTROL=0.
REQ-037 Contention: both valid for 4 cycles (alu_rd=1, lsu_rd=2) after reset -> grants ALU, LSU, ALU, LSU; rd_sel sequence 1,2,1,2 one cycle later; retire_cnt=4.
REQ-038 x0 write: lsu_valid=1, lsu_rd=0, lsu_data=0x1234 -> lsu_ready=1; wbe_CONTROL stays 0; retire_cnt increments to 1.
REQ-039 Stall: wb_stall=1 with both valid for 3 cycles -> both readies 0, wbe_CONTROL 0, retire_cnt unchanged; release -> ALU granted first.
REQ-040 Async reset mid-stream: continuous ALU transfers, then rst pulsed between clock edges -> outputs and retire_cnt read 0 before the next edge; no transfer while rst high.
REQ-041 Wrap: retire_cnt forced to 0xFFFFFFFF via 2^32-1 transfers or a shortened-counter build, then one transfer -> retire_cnt=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin choice between the ALU and LSU result sources, with the
// winner registered into the register-file write port and a count of accepted results.
module wb_arbiter #(
  parameter int unsigned XLEN     = 32,
  // Width of the internal retire counter; values below 32 give a short-wrapping build.
  parameter int unsigned CntWidth = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_stall,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            wbe_CONTROL,
  output logic [4:0]      rd_sel,
  output logic [XLEN-1:0] rd_in,
  output logic [31:0]     retire_cnt
);

  typedef enum logic {PtrAlu = 1'b0, PtrLsu = 1'b1} ptr_e;

  ptr_e                ptr_q;
  logic [CntWidth-1:0] cnt_q;
  logic                contended;
  logic                xfer;
  logic [4:0]          win_rd;
  logic [XLEN-1:0]     win_data;

  assign contended = alu_valid && lsu_valid;

  // The ALU wins when it is alone or when the pointer favours it under contention.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst && !wb_stall) begin
      if (alu_valid && (!lsu_valid || ptr_q == PtrAlu)) begin
        alu_ready = 1'b1;
      end else if (lsu_valid) begin
        lsu_ready = 1'b1;
      end
    end
  end

  assign xfer     = alu_ready || lsu_ready;
  assign win_rd   = alu_ready ? alu_rd : lsu_rd;
  assign win_data = alu_ready ? alu_data : lsu_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= PtrAlu;
      cnt_q       <= '0;
      wbe_CONTROL <= 1'b0;
      rd_sel      <= '0;
      rd_in       <= '0;
    end else begin
      wbe_CONTROL <= 1'b0;
      if (xfer) begin
        rd_sel      <= win_rd;
        rd_in       <= win_data;
        wbe_CONTROL <= (win_rd != 5'd0);
        cnt_q       <= cnt_q + CntWidth'(1);
        if (contended) begin
          ptr_q <= (ptr_q == PtrAlu) ? PtrLsu : PtrAlu;
        end
      end
    end
  end

  assign retire_cnt = 32'(cnt_q);

endmodule
